// File: rtl/channel_init_multi_if.sv
// Aurora ordered-set payload type and the lane-status / channel-status bundle.
// master: the channel init controller; slave: the lane side reporting status.
package aurora_pkg;
  typedef struct packed {
    logic sp;
    logic spa;
    logic ver;
    logic i;
    logic cc;
  } ordered_sets_t;
endpackage

interface channel_init_if #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned RETRY_W = 4
);
  logic [LANES-1:0]          lane_en;
  logic [LANES-1:0]          lane_aligned;
  logic [LANES-1:0]          lane_bonded;
  logic [LANES-1:0]          lane_verified;
  aurora_pkg::ordered_sets_t ordered_sets;
  logic                      init_finished;
  logic [2:0]                state_o;
  logic                      timeout_o;
  logic                      link_drop_o;
  logic [RETRY_W-1:0]        retry_cnt;
  logic                      failed;

  modport master (
    input  lane_en, lane_aligned, lane_bonded, lane_verified,
    output ordered_sets, init_finished, state_o, timeout_o, link_drop_o, retry_cnt, failed
  );

  modport slave (
    output lane_en, lane_aligned, lane_bonded, lane_verified,
    input  ordered_sets, init_finished, state_o, timeout_o, link_drop_o, retry_cnt, failed
  );
endinterface

// File: rtl/channel_init_multi.sv
// Multi-lane aurora channel init: RESET -> INIT -> BONDING -> VERIFICATION -> READY with watchdog.
// Define CHANNEL_INIT_RETRY_LIMIT_EN to park in FAILED once timeouts exceed MAX_RETRIES.
module channel_init_multi
  import aurora_pkg::*;
#(
  parameter int unsigned LANES          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned VER_CYCLES     = 8,
  parameter int unsigned RETRY_W        = 4,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           simplex_reset,
  channel_init_if.master ch
);
  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned VER_W   = (VER_CYCLES > 1) ? $clog2(VER_CYCLES) : 1;
  localparam ordered_sets_t OS_SP = '{sp: 1'b1, default: 1'b0};

  typedef enum logic [2:0] {
    S_RESET        = 3'd0,
    S_INIT         = 3'd1,
    S_BONDING      = 3'd2,
    S_VERIFICATION = 3'd3,
    S_READY        = 3'd4,
    S_FAILED       = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [VER_W-1:0]   ver_cnt_q, ver_cnt_d;
  logic [LANES-1:0]   en_q, en_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               failed_q, failed_d;
  ordered_sets_t      os_q, os_d;
  logic               fin_q, fin_d;
  logic               timeout_q, timeout_d;
  logic               drop_q, drop_d;
  logic               all_al, all_bd, all_vr, single, timer_max, expire, retry_exhausted;

  // Qualifiers only look at lanes latched into the mask during RESET.
  assign all_al    = &(ch.lane_aligned  | ~en_q);
  assign all_bd    = &(ch.lane_bonded   | ~en_q);
  assign all_vr    = &(ch.lane_verified | ~en_q);
  assign single    = (en_q != '0) && ((en_q & (en_q - LANES'(1))) == '0);
  assign timer_max = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

`ifdef CHANNEL_INIT_RETRY_LIMIT_EN
  assign retry_exhausted = (32'(retry_q) >= MAX_RETRIES);
`else
  logic unused_max_retries;
  assign unused_max_retries = ^MAX_RETRIES;
  assign retry_exhausted    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    ver_cnt_d = ver_cnt_q;
    en_d      = en_q;
    retry_d   = retry_q;
    failed_d  = failed_q;
    timeout_d = 1'b0;
    drop_d    = 1'b0;
    expire    = 1'b0;
    os_d      = '0;

    if (state_q == S_RESET) en_d = ch.lane_en;

    // Advancing transitions and alignment fallbacks take priority over the watchdog.
    case (state_q)
      S_RESET: if (en_q != '0) state_d = S_INIT;
      S_INIT: begin
        if (all_al) state_d = single ? S_VERIFICATION : S_BONDING;
        else        expire  = timer_max;
      end
      S_BONDING: begin
        if (!all_al)     state_d = S_INIT;
        else if (all_bd) state_d = S_VERIFICATION;
        else             expire  = timer_max;
      end
      S_VERIFICATION: begin
        if (!all_al)                                              state_d = S_INIT;
        else if (all_vr && (ver_cnt_q == VER_W'(VER_CYCLES - 1))) state_d = S_READY;
        else                                                      expire  = timer_max;
      end
      S_READY: begin
        if (!all_al) begin
          state_d = S_RESET;
          drop_d  = 1'b1;
        end
      end
      S_FAILED: state_d = S_FAILED;
      default:  state_d = S_RESET;
    endcase

    if (expire) begin
      timeout_d = 1'b1;
      retry_d   = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);
      state_d   = retry_exhausted ? S_FAILED : S_RESET;
      failed_d  = failed_q | retry_exhausted;
    end

    if (state_d != state_q) begin
      timer_d   = '0;
      ver_cnt_d = '0;
    end else begin
      timer_d   = (state_q inside {S_INIT, S_BONDING, S_VERIFICATION}) ? timer_q + TIMER_W'(1) : '0;
      ver_cnt_d = (state_q == S_VERIFICATION && all_vr) ? ver_cnt_q + VER_W'(1) : '0;
    end

    if (simplex_reset) begin
      state_d   = S_RESET;
      timer_d   = '0;
      ver_cnt_d = '0;
      retry_d   = '0;
      failed_d  = 1'b0;
      timeout_d = 1'b0;
      drop_d    = 1'b0;
    end

    // Outputs decode the next state so they line up with the state register.
    case (state_d)
      S_RESET, S_INIT: os_d.sp  = 1'b1;
      S_BONDING:       os_d.i   = 1'b1;
      S_VERIFICATION:  os_d.ver = 1'b1;
      default:         os_d     = '0;
    endcase
    fin_d = (state_d == S_READY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      timer_q   <= '0;
      ver_cnt_q <= '0;
      en_q      <= '0;
      retry_q   <= '0;
      failed_q  <= 1'b0;
      os_q      <= OS_SP;
      fin_q     <= 1'b0;
      timeout_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      ver_cnt_q <= ver_cnt_d;
      en_q      <= en_d;
      retry_q   <= retry_d;
      failed_q  <= failed_d;
      os_q      <= os_d;
      fin_q     <= fin_d;
      timeout_q <= timeout_d;
      drop_q    <= drop_d;
    end
  end

  assign ch.state_o       = state_q;
  assign ch.ordered_sets  = os_q;
  assign ch.init_finished = fin_q;
  assign ch.timeout_o     = timeout_q;
  assign ch.link_drop_o   = drop_q;
  assign ch.retry_cnt     = retry_q;
  assign ch.failed        = failed_q;
endmodule

// File: tb/tb_channel_init_multi.sv
// Scoreboard bench for channel_init_multi: expected state/timeout events are queued as stimulus
// is driven and popped when the DUT changes state or pulses timeout.
module tb_channel_init_multi;
  import aurora_pkg::*;

  localparam int unsigned LANES = 4;
  localparam int unsigned TO    = 16;
  localparam int unsigned VC    = 4;
  localparam int unsigned RW    = 4;
  localparam int unsigned MR    = 3;
  localparam logic [2:0] S_RESET = 3'd0, S_INIT = 3'd1, S_BOND = 3'd2,
                         S_VER = 3'd3, S_READY = 3'd4, S_FAILED = 3'd5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic simplex_reset = 1'b0;
  always #5 clk = ~clk;

  channel_init_if #(.LANES(LANES), .RETRY_W(RW)) ch ();

  channel_init_multi #(
    .LANES(LANES), .TIMEOUT_CYCLES(TO), .VER_CYCLES(VC), .RETRY_W(RW), .MAX_RETRIES(MR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .simplex_reset(simplex_reset), .ch(ch)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_to = 0;
  int n_drop = 0;
  bit have_last = 1'b0;
  bit mon_en = 1'b0;
  logic [2:0] prev_state = 3'd0;
  logic [2:0] exp_last = 3'd0;
  logic [2:0] mon_e;
  logic [RW-1:0] mon_r;
  logic [2:0] q_state[$];
  logic [RW-1:0] q_to[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4:0] os_of(input logic [2:0] s);
    ordered_sets_t o;
    o = '0;
    case (s)
      S_RESET, S_INIT: o.sp = 1'b1;
      S_BOND:          o.i = 1'b1;
      S_VER:           o.ver = 1'b1;
      default:         o = '0;
    endcase
    return o;
  endfunction

  task automatic push_state(input logic [2:0] s);
    q_state.push_back(s);
    exp_last = s;
  endtask

  task automatic do_reset(input logic [3:0] en, input logic [3:0] al,
                          input logic [3:0] bd, input logic [3:0] vr);
    @(posedge clk); #1;
    if (exp_last != S_RESET) push_state(S_RESET);
    rst_n = 1'b0;
    simplex_reset = 1'b0;
    ch.lane_en = en;
    ch.lane_aligned = al;
    ch.lane_bonded = bd;
    ch.lane_verified = vr;
    have_last = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ch.state_o == s) break;
    end
    check_eq(tag, 32'(ch.state_o), 32'(s));
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every state change and every timeout pulse consumes one expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ch.state_o != prev_state) begin
        if (q_state.size() == 0) begin
          check_eq("state_unexpected", 32'(ch.state_o), 32'(prev_state));
        end else begin
          mon_e = q_state.pop_front();
          check_eq("state_seq", 32'(ch.state_o), 32'(mon_e));
          check_eq("os_decode", 32'(ch.ordered_sets), 32'(os_of(mon_e)));
          check_eq("fin_decode", 32'(ch.init_finished), 32'(mon_e == S_READY));
        end
        prev_state = ch.state_o;
      end
      if (ch.timeout_o) begin
        if (q_to.size() == 0) begin
          check_eq("to_unexpected", 32'(ch.timeout_o), 32'(0));
        end else begin
          mon_r = q_to.pop_front();
          check_eq("to_retry", 32'(ch.retry_cnt), 32'(mon_r));
        end
        if (have_last) check_eq("to_period", 32'(cyc - last_to), 32'(TO + 1));
        last_to = cyc;
        have_last = 1'b1;
      end
      if (ch.link_drop_o) n_drop++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    int seen;
    ch.lane_en = '0;
    ch.lane_aligned = '0;
    ch.lane_bonded = '0;
    ch.lane_verified = '0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst_state", 32'(ch.state_o), 32'(S_RESET));
    check_eq("rst_os", 32'(ch.ordered_sets), 32'(os_of(S_RESET)));
    check_eq("rst_fin", 32'(ch.init_finished), 32'(0));
    check_eq("rst_timeout", 32'(ch.timeout_o), 32'(0));
    check_eq("rst_drop", 32'(ch.link_drop_o), 32'(0));
    check_eq("rst_retry", 32'(ch.retry_cnt), 32'(0));
    check_eq("rst_failed", 32'(ch.failed), 32'(0));
    mon_en = 1'b1;

    // Main flow: aligned at cycle 5, bonded at 10, verified from 12.
    do_reset(4'hF, 4'h0, 4'h0, 4'h0);
    push_state(S_INIT); push_state(S_BOND); push_state(S_VER); push_state(S_READY);
    repeat (5) @(posedge clk);
    #1 ch.lane_aligned = 4'hF;
    @(negedge clk);
    check_eq("a_init", 32'(ch.state_o), 32'(S_INIT));
    repeat (5) @(posedge clk);
    #1 ch.lane_bonded = 4'hF;
    @(negedge clk);
    check_eq("a_bond", 32'(ch.state_o), 32'(S_BOND));
    repeat (2) @(posedge clk);
    #1 ch.lane_verified = 4'hF;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("a_ver_latency", 32'(ch.state_o), 32'((k == 4) ? S_READY : S_VER));
    end
    check_eq("a_fin", 32'(ch.init_finished), 32'(1));

    // Single enabled lane skips BONDING; a later lane_en change is ignored.
    do_reset(4'b0100, 4'b0100, 4'b0000, 4'b0100);
    push_state(S_INIT); push_state(S_VER); push_state(S_READY);
    wait_state(S_READY, 30, "b_single_ready");
    ch.lane_en = 4'hF;
    repeat (4) @(negedge clk);
    check_eq("b_mask_frozen", 32'(ch.state_o), 32'(S_READY));

    // No lanes enabled: stay in RESET.
    do_reset(4'h0, 4'h0, 4'h0, 4'h0);
    repeat (6) @(negedge clk);
    check_eq("c_noen_state", 32'(ch.state_o), 32'(S_RESET));
    check_eq("c_noen_os", 32'(ch.ordered_sets), 32'(os_of(S_RESET)));

    // One timeout, then reach READY and drop alignment of lane 1 for a cycle.
    do_reset(4'hF, 4'h0, 4'h0, 4'h0);
    push_state(S_INIT); push_state(S_RESET);
    push_state(S_INIT); push_state(S_BOND); push_state(S_VER); push_state(S_READY);
    push_state(S_RESET);
    push_state(S_INIT); push_state(S_BOND); push_state(S_VER); push_state(S_READY);
    q_to.push_back(RW'(1));
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ch.timeout_o) break;
    end
    check_eq("d_timeout_seen", 32'(ch.timeout_o), 32'(1));
    ch.lane_aligned = 4'hF;
    ch.lane_bonded = 4'hF;
    ch.lane_verified = 4'hF;
    wait_state(S_READY, 30, "d_ready");
    check_eq("d_retry_pre", 32'(ch.retry_cnt), 32'(1));
    @(posedge clk); #1 ch.lane_aligned = 4'b1101;
    @(posedge clk); #1 ch.lane_aligned = 4'hF;
    @(negedge clk);
    check_eq("d_drop_pulse", 32'(ch.link_drop_o), 32'(1));
    check_eq("d_drop_state", 32'(ch.state_o), 32'(S_RESET));
    check_eq("d_drop_fin", 32'(ch.init_finished), 32'(0));
    check_eq("d_drop_retry", 32'(ch.retry_cnt), 32'(1));
    @(negedge clk);
    check_eq("d_drop_one_cycle", 32'(ch.link_drop_o), 32'(0));
    wait_state(S_READY, 30, "d_ready_again");
    check_eq("d_drop_count", 32'(n_drop), 32'(1));

    // Lane 3 loses verified after three good cycles: count restarts.
    do_reset(4'hF, 4'hF, 4'hF, 4'h0);
    push_state(S_INIT); push_state(S_BOND); push_state(S_VER); push_state(S_READY);
    wait_state(S_VER, 20, "e_in_ver");
    for (int i = 0; i < 8; i++) begin
      ch.lane_verified = (i == 3) ? 4'b0111 : 4'hF;
      @(negedge clk);
      check_eq("e_ver_restart", 32'(ch.state_o), 32'((i == 7) ? S_READY : S_VER));
    end

    // Bonding completes on the same cycle the watchdog expires: advance wins.
    do_reset(4'hF, 4'hF, 4'h0, 4'h0);
    push_state(S_INIT); push_state(S_BOND); push_state(S_VER);
    wait_state(S_BOND, 20, "f_in_bond");
    repeat (15) @(negedge clk);
    ch.lane_bonded = 4'hF;
    @(negedge clk);
    check_eq("f_adv_state", 32'(ch.state_o), 32'(S_VER));
    check_eq("f_adv_no_timeout", 32'(ch.timeout_o), 32'(0));
    check_eq("f_adv_retry", 32'(ch.retry_cnt), 32'(0));

    // Asynchronous reset mid-BONDING, between clock edges.
    do_reset(4'hF, 4'hF, 4'h0, 4'h0);
    push_state(S_INIT); push_state(S_BOND);
    wait_state(S_BOND, 20, "g_in_bond");
    repeat (2) @(negedge clk);
    #2;
    push_state(S_RESET);
    rst_n = 1'b0;
    #1;
    check_eq("g_async_state", 32'(ch.state_o), 32'(S_RESET));
    check_eq("g_async_os", 32'(ch.ordered_sets), 32'(os_of(S_RESET)));
    check_eq("g_async_fin", 32'(ch.init_finished), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Aligned never arrives: periodic watchdog timeouts.
    do_reset(4'hF, 4'h0, 4'h0, 4'h0);
    push_state(S_INIT);
`ifdef CHANNEL_INIT_RETRY_LIMIT_EN
    for (int k = 1; k <= MR; k++) begin
      push_state(S_RESET); push_state(S_INIT);
      q_to.push_back(RW'(k));
    end
    push_state(S_FAILED);
    q_to.push_back(RW'(MR + 1));
    seen = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (ch.timeout_o) seen++;
      if (seen == MR + 1) break;
    end
    check_eq("h_timeouts_seen", 32'(seen), 32'(MR + 1));
    repeat (20) @(negedge clk);
    check_eq("h_failed_state", 32'(ch.state_o), 32'(S_FAILED));
    check_eq("h_failed_flag", 32'(ch.failed), 32'(1));
    check_eq("h_failed_os", 32'(ch.ordered_sets), 32'(0));
    check_eq("h_failed_retry", 32'(ch.retry_cnt), 32'(MR + 1));
`else
    for (int k = 1; k <= 16; k++) begin
      push_state(S_RESET); push_state(S_INIT);
      q_to.push_back(RW'((k > 15) ? 15 : k));
    end
    seen = 0;
    for (int i = 0; i < 320; i++) begin
      @(negedge clk);
      if (ch.timeout_o) seen++;
      if (seen == 16) break;
    end
    check_eq("h_timeouts_seen", 32'(seen), 32'(16));
    check_eq("h_retry_sat", 32'(ch.retry_cnt), 32'(15));
    check_eq("h_failed_tied", 32'(ch.failed), 32'(0));
`endif
    @(posedge clk); #1 simplex_reset = 1'b1;
    push_state(S_RESET);
    @(posedge clk);
    @(negedge clk);
    check_eq("h_sr_state", 32'(ch.state_o), 32'(S_RESET));
    check_eq("h_sr_retry", 32'(ch.retry_cnt), 32'(0));
    check_eq("h_sr_failed", 32'(ch.failed), 32'(0));
    check_eq("h_sr_timeout", 32'(ch.timeout_o), 32'(0));
    repeat (3) @(negedge clk);
    check_eq("h_sr_hold", 32'(ch.state_o), 32'(S_RESET));

    check_eq("sb_state_drain", 32'(q_state.size()), 32'(0));
    check_eq("sb_timeout_drain", 32'(q_to.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
